vram_banked_arb: RTL and testbench

- Parametrised successor to the single-port banked VRAM.
- Splits VRAM into BANKS independent single-port banks and exposes two requesters:
  - video port: read-only, high priority
  - register/blitter port ("regs"): read/write
- Accesses to different banks in the same cycle both proceed. On a same-bank conflict video wins, with a starvation guard for regs.
- Sits between the video generator / register interface and physical VRAM (SPRAM banks on iCE40).

---
 rtl/vram_banked_arb.sv | 140 ++++++++++++++
 tb/tb_vram_banked_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vram_banked_arb.sv
// rtl/vram_banked_arb.sv - banked VRAM with video/regs two-port arbiter
//
// Optional feature macro: VRAM_NIBBLE_MASK_EN (per-nibble regs write mask).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   vid_req/vid_addr/vid_ack        video read request, granted same cycle
//   vid_rd_valid/vid_data_out       video read data, one cycle after ack
//   regs_req/regs_wr/regs_addr      regs request, write flag, address
//   regs_data_in/regs_wr_mask       write data, per-nibble write enable
//   regs_ack                        regs request granted same cycle
//   regs_rd_valid/regs_data_out     regs read data, one cycle after ack
module vram_banked_arb #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int BANKS      = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vid_req,
   input  logic [ADDR_W-1:0]     vid_addr,
   output logic                  vid_ack,
   output logic                  vid_rd_valid,
   output logic [DATA_W-1:0]     vid_data_out,
   input  logic                  regs_req,
   input  logic                  regs_wr,
   input  logic [ADDR_W-1:0]     regs_addr,
   input  logic [DATA_W-1:0]     regs_data_in,
   input  logic [DATA_W/4-1:0]   regs_wr_mask,
   output logic                  regs_ack,
   output logic                  regs_rd_valid,
   output logic [DATA_W-1:0]     regs_data_out
);

   localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 0;
   localparam int SEL_W  = (BANKS > 1) ? BANK_W : 1;
   localparam int OFF_W  = ADDR_W - BANK_W;
   localparam int DEPTH  = 1 << OFF_W;

   logic [SEL_W-1:0]  vid_bank, regs_bank;
   logic [SEL_W-1:0]  vid_bank_q, regs_bank_q;
   logic [OFF_W-1:0]  vid_off, regs_off;
   logic              force_regs;
   logic [7:0]        stall_cnt;
   logic              regs_stall;
   logic              vid_rv_q, regs_rv_q;
   logic [DATA_W-1:0] bit_mask;
   logic [DATA_W-1:0] rd_data [BANKS];

   generate
      if (BANKS > 1) begin : g_multi
         assign vid_bank  = vid_addr[ADDR_W-1 -: BANK_W];
         assign regs_bank = regs_addr[ADDR_W-1 -: BANK_W];
      end else begin : g_single
         assign vid_bank  = '0;
         assign regs_bank = '0;
      end
   endgenerate

   assign vid_off  = vid_addr[OFF_W-1:0];
   assign regs_off = regs_addr[OFF_W-1:0];

   // Video has priority unless the starvation guard fires; during that
   // one forced cycle video is blocked even on another bank.
   assign vid_ack    = vid_req & ~force_regs & ~reset;
   assign regs_ack   = regs_req & ~reset &
                       (~vid_req | (vid_bank != regs_bank) | force_regs);
   assign regs_stall = regs_req & ~regs_ack;

`ifdef VRAM_NIBBLE_MASK_EN
   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < DATA_W/4; i++)
         bit_mask[i*4 +: 4] = {4{regs_wr_mask[i]}};
   end
`else
   // Mask port kept for interface stability; every write is full-word.
   logic unused_wr_mask;
   assign unused_wr_mask = ^regs_wr_mask;
   assign bit_mask = '1;
`endif

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic              cs, we;
      logic [OFF_W-1:0]  addr;

      // Both ports can never be granted into the same bank: a same-bank
      // regs grant requires force_regs, which withholds vid_ack.
      always_comb begin
         cs   = 1'b0;
         we   = 1'b0;
         addr = vid_off;
         if (regs_ack && regs_bank == SEL_W'(b)) begin
            cs   = 1'b1;
            we   = regs_wr;
            addr = regs_off;
         end else if (vid_ack && vid_bank == SEL_W'(b)) begin
            cs   = 1'b1;
         end
      end

      // Read captures the pre-write contents, giving old-data semantics.
      always_ff @(posedge clk) begin
         if (cs) begin
            rd_data[b] <= mem[addr];
            if (we)
               mem[addr] <= (mem[addr] & ~bit_mask) | (regs_data_in & bit_mask);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vid_rv_q   <= 1'b0;
         regs_rv_q  <= 1'b0;
         force_regs <= 1'b0;
         stall_cnt  <= 8'd0;
      end else begin
         vid_rv_q   <= vid_ack;
         regs_rv_q  <= regs_ack & ~regs_wr;
         force_regs <= regs_stall && (stall_cnt == 8'(STARVE_MAX - 1));
         if (regs_ack)
            stall_cnt <= 8'd0;
         else if (regs_stall)
            stall_cnt <= stall_cnt + 8'd1;
         if (vid_ack)
            vid_bank_q <= vid_bank;
         if (regs_ack)
            regs_bank_q <= regs_bank;
      end
   end

   // Gating with reset drops a read granted just before reset asserts.
   assign vid_rd_valid  = vid_rv_q & ~reset;
   assign regs_rd_valid = regs_rv_q & ~reset;
   assign vid_data_out  = rd_data[vid_bank_q];
   assign regs_data_out = rd_data[regs_bank_q];

endmodule

// File: tb/tb_vram_banked_arb.sv
// tb/tb_vram_banked_arb.sv - scoreboard testbench for vram_banked_arb
module tb_vram_banked_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_ack;
   logic        vid_rd_valid;
   logic [15:0] vid_data_out;
   logic        regs_req;
   logic        regs_wr;
   logic [15:0] regs_addr;
   logic [15:0] regs_data_in;
   logic [3:0]  regs_wr_mask;
   logic        regs_ack;
   logic        regs_rd_valid;
   logic [15:0] regs_data_out;

   int checks = 0;
   int passes = 0;
   logic [15:0] vq[$];
   logic [15:0] rq[$];

   vram_banked_arb #(.ADDR_W(16), .DATA_W(16), .BANKS(4), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_rd_valid(vid_rd_valid), .vid_data_out(vid_data_out),
      .regs_req(regs_req), .regs_wr(regs_wr), .regs_addr(regs_addr),
      .regs_data_in(regs_data_in), .regs_wr_mask(regs_wr_mask),
      .regs_ack(regs_ack), .regs_rd_valid(regs_rd_valid),
      .regs_data_out(regs_data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: pops expected read data whenever the DUT presents rd_valid.
   always @(negedge clk) begin
      if (vid_rd_valid) begin
         if (vq.size() == 0) begin
            checks++;
            $display("FAIL vid_unexpected_rd_valid: got 1 expected 0");
         end else chk("vid_data", {16'h0, vid_data_out}, {16'h0, vq.pop_front()});
      end
      if (regs_rd_valid) begin
         if (rq.size() == 0) begin
            checks++;
            $display("FAIL regs_unexpected_rd_valid: got 1 expected 0");
         end else chk("regs_data", {16'h0, regs_data_out}, {16'h0, rq.pop_front()});
      end
   end

   // One cycle: drive at posedge+1, check acks at negedge, queue expected reads.
   task automatic cyc(input logic vr, input logic [15:0] va,
                      input logic rr, input logic rw, input logic [15:0] ra,
                      input logic [15:0] rd, input logic [3:0] rm,
                      input logic ev, input logic er,
                      input logic [15:0] evd, input logic [15:0] erd,
                      input string tag);
      vid_req = vr; vid_addr = va;
      regs_req = rr; regs_wr = rw; regs_addr = ra;
      regs_data_in = rd; regs_wr_mask = rm;
      @(negedge clk);
      chk({tag, "_vid_ack"}, {31'h0, vid_ack}, {31'h0, ev});
      chk({tag, "_regs_ack"}, {31'h0, regs_ack}, {31'h0, er});
      if (vid_ack && ev) vq.push_back(evd);
      if (regs_ack && er && !rw) rq.push_back(erd);
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [3:0] m, input string tag);
      cyc(0, 16'h0, 1, 1, a, d, m, 0, 1, 16'h0, 16'h0, tag);
   endtask

   task automatic idle();
      cyc(0, 16'h0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0, 16'h0, "idle");
   endtask

   initial begin
      logic [15:0] mask_exp;
`ifdef VRAM_NIBBLE_MASK_EN
      mask_exp = 16'hF0F0;
`else
      mask_exp = 16'h0000;
`endif
      reset = 1'b1;
      vid_req = 1'b1; vid_addr = 16'h4000;
      regs_req = 1'b1; regs_wr = 1'b0; regs_addr = 16'h8000;
      regs_data_in = 16'h0; regs_wr_mask = 4'hF;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_vid_ack", {31'h0, vid_ack}, 32'h0);
      chk("rst_regs_ack", {31'h0, regs_ack}, 32'h0);
      chk("rst_vid_rd_valid", {31'h0, vid_rd_valid}, 32'h0);
      chk("rst_regs_rd_valid", {31'h0, regs_rd_valid}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Write then read back through regs.
      wr(16'h0010, 16'h1234, 4'hF, "t1_wr");
      cyc(0, 16'h0, 1, 0, 16'h0010, 16'h0, 4'hF, 0, 1, 16'h0, 16'h1234, "t1_rd");
      idle();

      wr(16'h4000, 16'hA5A5, 4'hF, "init_4000");
      wr(16'h8000, 16'h5A5A, 4'hF, "init_8000");
      wr(16'h4001, 16'h1111, 4'hF, "init_4001");
      wr(16'h3000, 16'h0BAD, 4'hF, "init_3000");
      wr(16'h2000, 16'hFFFF, 4'hF, "init_2000");

      // Different banks proceed together.
      cyc(1, 16'h4000, 1, 0, 16'h8000, 16'h0, 4'hF, 1, 1, 16'hA5A5, 16'h5A5A, "t2");

      // Same-bank conflict: four stalls then one forced regs cycle, twice.
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < 4; i++)
            cyc(1, 16'h4000, 1, 0, 16'h4001, 16'h0, 4'hF, 1, 0, 16'hA5A5, 16'h0, "t3_stall");
         cyc(1, 16'h4000, 1, 0, 16'h4001, 16'h0, 4'hF, 0, 1, 16'h0, 16'h1111, "t3_force");
      end
      cyc(1, 16'h4000, 0, 0, 16'h0, 16'h0, 4'hF, 1, 0, 16'hA5A5, 16'h0, "t3_resume");

      // Nibble mask write.
      wr(16'h2000, 16'h0000, 4'b0101, "t4_wr");
      cyc(0, 16'h0, 1, 0, 16'h2000, 16'h0, 4'hF, 0, 1, 16'h0, mask_exp, "t4_rd");

      // Forced regs write into the bank video is reading.
      for (int i = 0; i < 4; i++)
         cyc(1, 16'h3000, 1, 1, 16'h3000, 16'hBEEF, 4'hF, 1, 0, 16'h0BAD, 16'h0, "t5_stall");
      cyc(1, 16'h3000, 1, 1, 16'h3000, 16'hBEEF, 4'hF, 0, 1, 16'h0, 16'h0, "t5_force");
      cyc(1, 16'h3000, 0, 0, 16'h0, 16'h0, 4'hF, 1, 0, 16'hBEEF, 16'h0, "t5_vid");
      idle();

      // Video read granted, then reset: no rd_valid may follow.
      vid_req = 1'b1; vid_addr = 16'h4000; regs_req = 1'b0;
      @(negedge clk);
      chk("t6_vid_ack", {31'h0, vid_ack}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_vid_ack", {31'h0, vid_ack}, 32'h0);
      chk("t6_rst_vid_rd_valid", {31'h0, vid_rd_valid}, 32'h0);
      chk("t6_rst_regs_rd_valid", {31'h0, regs_rd_valid}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      vid_req = 1'b0;
      @(negedge clk);
      chk("t6_post_vid_rd_valid", {31'h0, vid_rd_valid}, 32'h0);
      @(posedge clk); #1;
      cyc(1, 16'h4001, 1, 0, 16'h0010, 16'h0, 4'hF, 1, 1, 16'h1111, 16'h1234, "t6_persist");
      idle();
      idle();

      chk("vid_queue_drained", vq.size(), 32'h0);
      chk("regs_queue_drained", rq.size(), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
